// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Two requesters share one fixed-latency memory port. Port 0 is the core's
//   data/fetch path and port 1 is a secondary master such as DMA or a debug
//   loader. A transaction is one IDLE cycle, in which requests are sampled,
//   followed by an ACCESS phase. During ACCESS the address, the write data and
//   the active strobe are held for RD_LAT cycles (read) or WR_LAT cycles (write).
//
// Ports
//   clk, reset            clock; asynchronous active-low reset
//   req/we/addr/wdata N   requester N: level request, held until gntN
//   gnt N                 one-cycle pulse, request latched and inputs free
//   done N                one-cycle pulse, transaction finished (rdataN valid)
//   rdata N               last read data of port N, held until its next read
//   busy                  high while a transaction occupies the memory port
//   mem_*                 registered memory address, data and strobes
//
// Parameters
//   AW, DW                address and data widths
//   RD_LAT, WR_LAT        strobe high time in cycles (both >= 1)
//   FIXED_PRI             0 = round-robin, 1 = port 0 always wins
module mem_port_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int RD_LAT    = 3,
  parameter int WR_LAT    = 1,
  parameter int FIXED_PRI = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_write_data,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_read_data
);

  localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CW      = $clog2(MAX_LAT) + 1;
  localparam logic [CW-1:0] RD_LOAD = CW'(RD_LAT - 1);
  localparam logic [CW-1:0] WR_LOAD = CW'(WR_LAT - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          cur_port, cur_port_nxt;
  logic          cur_we, cur_we_nxt;
  logic          last_grant, last_grant_nxt;
  logic          gnt0_nxt, gnt1_nxt, done0_nxt, done1_nxt;
  logic [DW-1:0] rdata0_nxt, rdata1_nxt;
  logic [AW-1:0] mem_addr_nxt;
  logic [DW-1:0] mem_write_data_nxt;
  logic          mem_read_nxt, mem_write_nxt;

  // Arbitration of the requests presented in IDLE.
  logic          win_valid;
  logic          win_port;
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;

  always_comb begin
    win_valid = req0 | req1;
    win_port  = 1'b0;
    if (req0 && req1) begin
      // Under contention round-robin hands the port to whoever did not
      // have it last; last_grant resets to 1 so port 0 wins the first clash.
      win_port = (FIXED_PRI != 0) ? 1'b0 : ~last_grant;
    end else if (req1) begin
      win_port = 1'b1;
    end
    win_we    = win_port ? we1    : we0;
    win_addr  = win_port ? addr1  : addr0;
    win_wdata = win_port ? wdata1 : wdata0;
  end

  always_comb begin
    state_nxt          = state;
    cnt_nxt            = cnt;
    cur_port_nxt       = cur_port;
    cur_we_nxt         = cur_we;
    last_grant_nxt     = last_grant;
    gnt0_nxt           = 1'b0;
    gnt1_nxt           = 1'b0;
    done0_nxt          = 1'b0;
    done1_nxt          = 1'b0;
    rdata0_nxt         = rdata0;
    rdata1_nxt         = rdata1;
    mem_addr_nxt       = mem_addr;
    mem_write_data_nxt = mem_write_data;
    mem_read_nxt       = mem_read;
    mem_write_nxt      = mem_write;

    case (state)
      IDLE: begin
        if (win_valid) begin
          state_nxt      = ACCESS;
          cur_port_nxt   = win_port;
          cur_we_nxt     = win_we;
          last_grant_nxt = win_port;
          mem_addr_nxt   = win_addr;
          if (win_we) begin
            mem_write_data_nxt = win_wdata;
          end
          mem_read_nxt  = ~win_we;
          mem_write_nxt = win_we;
          // The strobe rises with the ACCESS state, so the count starts one
          // short of the latency and the final cycle is the one at cnt == 0.
          cnt_nxt  = win_we ? WR_LOAD : RD_LOAD;
          gnt0_nxt = ~win_port;
          gnt1_nxt = win_port;
        end
      end

      ACCESS: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CW'(1);
        end else begin
          state_nxt     = IDLE;
          mem_read_nxt  = 1'b0;
          mem_write_nxt = 1'b0;
          if (!cur_we) begin
            if (cur_port) begin
              rdata1_nxt = mem_read_data;
            end else begin
              rdata0_nxt = mem_read_data;
            end
          end
          done0_nxt = ~cur_port;
          done1_nxt = cur_port;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      cnt            <= '0;
      cur_port       <= 1'b0;
      cur_we         <= 1'b0;
      last_grant     <= 1'b1;
      gnt0           <= 1'b0;
      gnt1           <= 1'b0;
      done0          <= 1'b0;
      done1          <= 1'b0;
      rdata0         <= '0;
      rdata1         <= '0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      cur_port       <= cur_port_nxt;
      cur_we         <= cur_we_nxt;
      last_grant     <= last_grant_nxt;
      gnt0           <= gnt0_nxt;
      gnt1           <= gnt1_nxt;
      done0          <= done0_nxt;
      done1          <= done1_nxt;
      rdata0         <= rdata0_nxt;
      rdata1         <= rdata1_nxt;
      mem_addr       <= mem_addr_nxt;
      mem_write_data <= mem_write_data_nxt;
      mem_read       <= mem_read_nxt;
      mem_write      <= mem_write_nxt;
    end
  end

  assign busy = (state == ACCESS);

endmodule
